// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
//   state_t        FSM encoding for serial_sub4 (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  default operand/result width in bits
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_sub.sv
// full_sub: combinational 1-bit full subtractor computing x - y - bin.
// Ports:
//   x     in   minuend bit
//   y     in   subtrahend bit
//   bin   in   borrow in
//   diff  out  difference bit
//   bout  out  borrow out
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    always_comb begin
        diff = x ^ y ^ bin;
        // Borrow when y exceeds x outright, or when they are equal and a borrow ripples in.
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial unsigned subtractor, d = a - b, one bit per clock, LSB first.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled in IDLE or in the DONE cycle
//   a      in   minuend, captured on the accepting edge
//   b      in   subtrahend, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when d/bo are updated
//   d      out  (a - b) mod 2^WIDTH, held until the next result
//   bo     out  final borrow, 1 iff a < b
module serial_sub4
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    // Counter holds 0..WIDTH, so it never wraps within an operation.
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             diff_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;

    full_sub u_full_sub (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .diff (diff_bit),
        .bout (bout_bit)
    );

    // Result fills from the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_next = {diff_bit, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= bout_bit;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        d     <= res_next;
                        bo    <= bout_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: self-checking bench for serial_sub4 at WIDTH=4.
module tb_serial_sub4;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W-1:0] last_exp_d = '0;

    serial_sub4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vd;
        logic         vbo;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Launch one operation from the current (post-edge) point and wait for its done pulse.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int   lat;
        logic seen;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({nm, " busy_after_accept"}, int'(busy), 1);
        lat  = 99;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else if (i == 2) begin
                check({nm, " d_held_midop"}, int'(d), int'(last_exp_d));
            end
        end
        check({nm, " latency"}, lat, W);
        check({nm, " d"}, int'(d), int'(ed));
        check({nm, " bo"}, int'(bo), int'(eb));
        check({nm, " busy_at_done"}, int'(busy), 0);
        last_exp_d = ed;
    endtask

    initial begin
        int dc0;
        logic [W-1:0] ed;

        // Hand-computed vectors.
        vecs[0] = '{va: 4'd7,  vb: 4'd3,  vd: 4'd4,  vbo: 1'b0};
        vecs[1] = '{va: 4'd3,  vb: 4'd7,  vd: 4'd12, vbo: 1'b1};
        vecs[2] = '{va: 4'd0,  vb: 4'd15, vd: 4'd1,  vbo: 1'b1};
        vecs[3] = '{va: 4'd15, vb: 4'd15, vd: 4'd0,  vbo: 1'b0};
        vecs[4] = '{va: 4'd0,  vb: 4'd0,  vd: 4'd0,  vbo: 1'b0};
        vecs[5] = '{va: 4'd12, vb: 4'd5,  vd: 4'd7,  vbo: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset d", int'(d), 0);
        check("reset bo", int'(bo), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vd, vecs[i].vbo, $sformatf("vec%0d", i));
        end
        @(posedge clk);
        #1;

        // Start during SHIFT must be ignored; exactly one done pulse.
        dc0   = done_cnt;
        a     = 4'd9;
        b     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a     = 4'd1;
        b     = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ignore done", int'(done), 1);
        check("ignore d", int'(d), 7);
        check("ignore bo", int'(bo), 0);
        repeat (6) @(posedge clk);
        #1;
        check("ignore one_done", done_cnt - dc0, 1);
        check("ignore idle", int'(busy), 0);
        last_exp_d = 4'd7;

        // Back-to-back with start held high; second operands shown on the done cycle.
        a     = 4'd5;
        b     = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= W; i++) begin
            if (i < W) check($sformatf("b2b busy c%0d", i), int'(busy), 1);
            @(posedge clk);
            #1;
        end
        check("b2b first done", int'(done), 1);
        check("b2b first d", int'(d), 15);
        check("b2b first bo", int'(bo), 1);
        check("b2b first busy", int'(busy), 0);
        a = 4'd8;
        b = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b reaccept busy", int'(busy), 1);
        check("b2b reaccept done", int'(done), 0);
        repeat (W - 1) @(posedge clk);
        #1;
        check("b2b second not_early", int'(done), 0);
        @(posedge clk);
        #1;
        check("b2b second done", int'(done), 1);
        check("b2b second d", int'(d), 7);
        check("b2b second bo", int'(bo), 0);
        last_exp_d = 4'd7;
        @(posedge clk);
        #1;

        // Reset asserted during the second SHIFT cycle.
        a     = 4'd12;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort d", int'(d), 0);
        check("abort bo", int'(bo), 0);
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort no_done", done_cnt - dc0, 0);
        check("abort still_idle", int'(busy), 0);
        last_exp_d = '0;
        run_op(4'd10, 4'd4, 4'd6, 1'b0, "after_abort");

        // Exhaustive sweep against a modular-arithmetic model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ed = W'(ia - ib);
                run_op(W'(ia), W'(ib), ed, (ia < ib), $sformatf("sweep a%0d b%0d", ia, ib));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
